fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 60 ++++++
 rtl/fetch_unit_phase_gen.sv | 34 +++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// opcodes package
// Shared between the fetch unit and the control block.
//   phase_t    : Fetch / Read / Execute instruction phase.
//   PcSel_t    : PC update source (increment or jump).
//   opcodes_t  : instruction opcode field IR[15:12].
//   Field slice constants for the 16-bit instruction word, plus a helper
//   that gives the successor of a phase.
// -----------------------------------------------------------------------------
package opcodes;

  typedef enum logic [1:0] {
    PhFetch   = 2'd0,
    PhRead    = 2'd1,
    PhExecute = 2'd2
  } phase_t;

  typedef enum logic {
    PcInc = 1'b0,
    PcJmp = 1'b1
  } PcSel_t;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpLdi  = 4'h1,
    OpAdd  = 4'h2,
    OpSub  = 4'h3,
    OpAnd  = 4'h4,
    OpOr   = 4'h5,
    OpXor  = 4'h6,
    OpShl  = 4'h7,
    OpShr  = 4'h8,
    OpLd   = 4'h9,
    OpSt   = 4'hA,
    OpCmp  = 4'hB,
    OpJmp  = 4'hC,
    OpJz   = 4'hD,
    OpWait = 4'hE,
    OpHalt = 4'hF
  } opcodes_t;

  // Instruction word field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int REG_MSB = 11;
  localparam int REG_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Phases advance unconditionally; the unused encoding falls back to Fetch.
  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PhFetch:   return PhRead;
      PhRead:    return PhExecute;
      PhExecute: return PhFetch;
      default:   return PhFetch;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_phase_gen.sv
// -----------------------------------------------------------------------------
// phase_gen
// Free-running three-phase sequencer Fetch -> Read -> Execute -> Fetch.
// The same block is instantiated by control so both stay in lockstep.
//   Clock : rising-edge clock
//   Reset : synchronous active-high reset, forces Fetch
//   Phase : registered current phase
// -----------------------------------------------------------------------------
module phase_gen
  import opcodes::*;
(
  input  logic   Clock,
  input  logic   Reset,
  output phase_t Phase
);

  phase_t phase_q;
  phase_t phase_d;

  always_comb begin
    phase_d = next_phase(phase_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q <= PhFetch;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign Phase = phase_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end for an external synchronous program ROM.
// One instruction takes three cycles: Fetch presents PC, Read captures the
// ROM word into IR, Execute applies the PC update requested by control.
//   Clock, Reset : clock and synchronous active-high reset
//   PcWe, PcSel  : PC write enable / source, honoured only in Execute
//   RomAddr      : ROM address (always the PC)
//   RomData      : ROM word, valid in the cycle after RomAddr
//   OpCode/Instr : decoded opcode / full instruction register
//   InstrValid   : IR has been loaded at least once since reset
//   Phase        : current Fetch/Read/Execute phase
//   Halted       : sticky, set when a jump targets its own address
//   PcWrap       : one-cycle pulse after PC increments past all-ones
// -----------------------------------------------------------------------------
module fetch_unit
  import opcodes::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   PcWe,
  input  PcSel_t                 PcSel,
  output logic [PC_WIDTH-1:0]    RomAddr,
  input  logic [INSTR_WIDTH-1:0] RomData,
  output opcodes_t               OpCode,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic                   InstrValid,
  output phase_t                 Phase,
  output logic                   Halted,
  output logic                   PcWrap
);

  phase_t phase;

  logic [PC_WIDTH-1:0]    pc_q,     pc_d;
  logic [INSTR_WIDTH-1:0] ir_q,     ir_d;
  logic                   valid_q,  valid_d;
  logic                   halted_q, halted_d;
  logic                   wrap_q,   wrap_d;

  logic [PC_WIDTH-1:0]    jmp_target;

  phase_gen u_phase_gen (
    .Clock (Clock),
    .Reset (Reset),
    .Phase (phase)
  );

  assign jmp_target = ir_q[PC_WIDTH-1:0];

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    wrap_d   = 1'b0;          // pulse: only high for the cycle after a wrap

    case (phase)
      // RomData is only meaningful here; IR never loads in any other phase.
      PhRead: begin
        ir_d    = RomData;
        valid_d = 1'b1;
      end
      PhExecute: begin
        if (PcWe) begin
          if (PcSel == PcJmp) begin
            pc_d = jmp_target;
            if (jmp_target == pc_q) begin
              halted_d = 1'b1;
            end
          end else begin
            pc_d   = pc_q + 1'b1;
            wrap_d = &pc_q;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      wrap_q   <= wrap_d;
    end
  end

  assign RomAddr    = pc_q;
  assign Instr      = ir_q;
  assign OpCode     = opcodes_t'(ir_q[OPC_MSB:OPC_LSB]);
  assign InstrValid = valid_q;
  assign Phase      = phase;
  assign Halted     = halted_q;
  assign PcWrap     = wrap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Instruction-level reference model with a scoreboard queue. The stimulus
// process predicts each instruction (address, word, Halted, PcWrap) from the
// ROM image and PC rules and pushes it; a monitor pops and compares whenever
// the DUT is in Execute with a valid instruction.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import opcodes::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        PcWe  = 1'b0;
  PcSel_t      PcSel = PcInc;
  logic [7:0]  RomAddr;
  logic [15:0] RomData = 16'h0;
  opcodes_t    OpCode;
  logic [15:0] Instr;
  logic        InstrValid;
  phase_t      Phase;
  logic        Halted;
  logic        PcWrap;

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .PcWe       (PcWe),
    .PcSel      (PcSel),
    .RomAddr    (RomAddr),
    .RomData    (RomData),
    .OpCode     (OpCode),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .Phase      (Phase),
    .Halted     (Halted),
    .PcWrap     (PcWrap)
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM; outside the Read cycle the data bus carries junk so an
  // IR load in the wrong phase shows up as a wrong instruction.
  logic [15:0] rom [256];
  always @(posedge Clock) begin
    if (Phase == PhFetch) RomData <= rom[RomAddr];
    else                  RomData <= 16'($urandom);
  end

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        halted;
    logic        wrap;
  } item_t;

  item_t q[$];

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;

  // Model state: the architectural view at the start of the next instruction
  logic [7:0] m_pc;
  logic       m_halted;
  logic       m_wrap;
  bit         armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic fetch_wrap = 1'b0;
  always @(negedge Clock) begin
    if (armed) begin
      if (Phase == PhFetch) fetch_wrap = PcWrap;
      if (Phase == PhExecute && InstrValid) begin
        item_t it;
        if (q.size() == 0) begin
          check("queue_underflow", 32'(q.size()), 32'd1);
        end else begin
          it = q.pop_front();
          popped++;
          $display("instr pc=%02h word=%04h op=%0h halted=%0b wrap=%0b", RomAddr, Instr, OpCode, Halted, fetch_wrap);
          check("rom_addr", 32'(RomAddr), 32'(it.pc));
          check("instr",    32'(Instr),   32'(it.instr));
          check("opcode",   32'(OpCode),  32'(it.instr[15:12]));
          check("halted",   32'(Halted),  32'(it.halted));
          check("wrap",     32'(fetch_wrap), 32'(it.wrap));
          check("wrap_exec", 32'(PcWrap), 32'd0);
        end
      end
    end
  end

  // Entered at a negedge; leaves at a negedge inside the first Fetch cycle.
  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_phase",  32'(Phase),      32'(PhFetch));
    check("rst_pc",     32'(RomAddr),    32'd0);
    check("rst_valid",  32'(InstrValid), 32'd0);
    check("rst_ir",     32'(Instr),      32'd0);
    check("rst_halted", 32'(Halted),     32'd0);
    check("rst_wrap",   32'(PcWrap),     32'd0);
    Reset    = 1'b0;
    m_pc     = 8'h00;
    m_halted = 1'b0;
    m_wrap   = 1'b0;
    armed    = 1;
  endtask

  // One instruction, starting at a negedge in Fetch. If rst_exec is set, reset
  // is raised during Execute together with a jump request that must be lost.
  task automatic run_instr(input logic we, input PcSel_t sel, input bit rst_exec);
    item_t it;
    logic [7:0] tgt;
    it.pc = m_pc; it.instr = rom[m_pc]; it.halted = m_halted; it.wrap = m_wrap;
    q.push_back(it);
    pushed++;
    // Requests outside Execute must have no effect
    PcWe = 1'($urandom_range(0, 1)); PcSel = PcSel_t'($urandom_range(0, 1));
    @(negedge Clock);
    PcWe = 1'($urandom_range(0, 1)); PcSel = PcSel_t'($urandom_range(0, 1));
    @(negedge Clock);
    if (rst_exec) begin
      PcWe = 1'b1; PcSel = PcJmp;
      do_reset();
      return;
    end
    PcWe = we; PcSel = sel;
    m_wrap = 1'b0;
    if (we) begin
      if (sel == PcJmp) begin
        tgt = it.instr[7:0];
        if (tgt == m_pc) m_halted = 1'b1;
        m_pc = tgt;
      end else begin
        m_wrap = (m_pc == 8'hFF);
        m_pc   = m_pc + 8'd1;
      end
    end
    @(negedge Clock);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[8'h00] = 16'h1234;
    rom[8'h01] = 16'hC005;   // jump to 5
    rom[8'h05] = 16'hC020;   // jump to 0x20
    rom[8'h20] = 16'hC007;   // jump to 7
    rom[8'h07] = 16'h2108;
    rom[8'h08] = 16'hC033;   // jump to 0x33
    rom[8'h33] = 16'hC033;   // jump to self
    rom[8'h34] = 16'hC0FF;   // jump to 0xFF

    repeat (3) @(negedge Clock);
    do_reset();

    run_instr(1'b1, PcInc, 0);                 // 0x00 -> 0x01
    run_instr(1'b1, PcJmp, 0);                 // 0x01 -> 0x05
    run_instr(1'b1, PcJmp, 0);                 // 0x05 -> 0x20
    run_instr(1'b1, PcJmp, 0);                 // 0x20 -> 0x07
    repeat (3) run_instr(1'b0, PcJmp, 0);      // WAIT at 0x07
    run_instr(1'b1, PcInc, 0);                 // 0x07 -> 0x08
    run_instr(1'b1, PcJmp, 0);                 // 0x08 -> 0x33
    repeat (11) run_instr(1'b1, PcJmp, 0);     // self jump, Halted sticks
    run_instr(1'b1, PcInc, 0);                 // 0x33 -> 0x34
    run_instr(1'b1, PcJmp, 0);                 // 0x34 -> 0xFF
    run_instr(1'b1, PcInc, 0);                 // 0xFF -> 0x00, wrap
    run_instr(1'b1, PcInc, 0);                 // wrap must not repeat
    run_instr(1'b1, PcInc, 1);                 // reset mid-Execute

    for (int n = 0; n < 120; n++) begin
      run_instr(1'($urandom_range(0, 3) != 0), PcSel_t'($urandom_range(0, 1)), 0);
    end
    run_instr(1'b1, PcInc, 1);

    check("drained", 32'(popped), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
